// File: rtl/binary_unpack_if.sv
// ---------------------------------------------------------------------------
// binary_unpack_if
//   Groups the packed-byte input handshake and the expanded-pixel output
//   handshake of binary_unpack.
//   Signals:
//     in_data   [7:0]  packed byte, bit 7 = leftmost pixel
//     in_valid         in_data valid
//     in_ready         unpacker can take in_data this cycle
//     binary    [7:0]  expanded pixel (WHITE or BLACK)
//     out_valid        binary valid
//     out_ready        downstream takes binary this cycle
//     out_sol          presented pixel is column 0
//     out_eol          presented pixel is the last column
//     out_eof          presented pixel is the last pixel of the frame
//   Modports:
//     master : the environment (drives bytes in, consumes pixels)
//     slave  : the unpacker itself
// ---------------------------------------------------------------------------
interface binary_unpack_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] binary;
    logic       out_valid;
    logic       out_ready;
    logic       out_sol;
    logic       out_eol;
    logic       out_eof;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, binary, out_valid, out_sol, out_eol, out_eof
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, binary, out_valid, out_sol, out_eol, out_eof
    );
endinterface

// File: rtl/binary_unpack.sv
// ---------------------------------------------------------------------------
// binary_unpack
//   Expands a packed 1-bit-per-pixel stream (8 pixels per byte, MSB first)
//   into one 8-bit pixel per clock (WHITE for 1, BLACK for 0) with
//   start-of-line / end-of-line / end-of-frame markers.
//   Every line starts on a fresh byte; padding bits past the end of a line
//   in its final byte are dropped.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - binary_unpack_if.slave (byte input and pixel output handshakes)
// ---------------------------------------------------------------------------
module binary_unpack #(
    parameter int         IMG_WIDTH  = 640,
    parameter int         IMG_HEIGHT = 480,
    parameter logic [7:0] WHITE      = 8'd255,
    parameter logic [7:0] BLACK      = 8'd0
) (
    input  logic            clk,
    input  logic            rst,
    binary_unpack_if.slave  bus
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic {
        EMPTY  = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       sr_reg,    sr_next;     // MSB is the presented pixel
    logic [3:0]       bits_reg,  bits_next;   // used bits still held, incl. presented
    logic [COL_W-1:0] col_reg,   col_next;
    logic [ROW_W-1:0] row_reg,   row_next;

    logic        pop;
    logic        last_bit;
    logic        in_ready_c;
    logic [31:0] remaining;
    logic [3:0]  used_bits;

    assign pop      = (state_reg == EXPAND) && bus.out_ready;
    assign last_bit = (bits_reg == 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            sr_reg    <= '0;
            bits_reg  <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            bits_reg  <= bits_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        bits_next  = bits_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        in_ready_c = 1'b0;
        remaining  = '0;
        used_bits  = '0;

        if (pop) begin
            if (col_reg == COL_LAST) begin
                col_next = '0;
                row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
            sr_next   = {sr_reg[6:0], 1'b0};
            bits_next = bits_reg - 4'd1;
            if (last_bit) begin
                state_next = EMPTY;
            end
        end

        // A new byte may land in the same cycle the last used bit leaves,
        // so the bit budget is taken from the column after this cycle's pop.
        in_ready_c = (state_reg == EMPTY) || (pop && last_bit);
        remaining  = 32'(IMG_WIDTH) - 32'(col_next);
        used_bits  = (remaining >= 32'd8) ? 4'd8 : remaining[3:0];

        if (bus.in_valid && in_ready_c) begin
            sr_next    = bus.in_data;
            bits_next  = used_bits;
            state_next = EXPAND;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_reg == EXPAND);
    assign bus.binary    = sr_reg[7] ? WHITE : BLACK;
    assign bus.out_sol   = (state_reg == EXPAND) && (col_reg == '0);
    assign bus.out_eol   = (state_reg == EXPAND) && (col_reg == COL_LAST);
    assign bus.out_eof   = (state_reg == EXPAND) && (col_reg == COL_LAST)
                           && (row_reg == ROW_LAST);

endmodule

// File: tb/tb_binary_unpack.sv
module tb_binary_unpack;

    localparam int W = 12;
    localparam int H = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    binary_unpack_if bus();

    binary_unpack #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .WHITE     (8'd255),
        .BLACK     (8'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] pix;
        logic       sol;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t       q[$];
    logic [7:0] pop_log[$];
    int col_m = 0;
    int row_m = 0;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int pop_count = 0;
    int first_pop_cyc = -1;
    int last_pop_cyc = -1;
    int eof_pop_idx = -1;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a byte accepted at column c yields min(8, W-c) pixels, MSB first.
    task automatic model_byte(input logic [7:0] b);
        int   used;
        exp_t e;
        used = (W - col_m < 8) ? (W - col_m) : 8;
        $display("[TB] byte %02h accepted at row %0d col %0d, %0d pixels", b, row_m, col_m, used);
        for (int i = 0; i < used; i++) begin
            e.pix = b[7-i] ? 8'd255 : 8'd0;
            e.sol = (col_m == 0);
            e.eol = (col_m == W - 1);
            e.eof = (col_m == W - 1) && (row_m == H - 1);
            q.push_back(e);
            col_m++;
            if (col_m == W) begin
                col_m = 0;
                row_m = (row_m + 1) % H;
            end
        end
    endtask

    // Monitor: samples on the falling edge, i.e. the values that the next
    // rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            col_m = 0;
            row_m = 0;
        end else begin
            check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            check("in_ready", 32'(bus.in_ready),
                  32'((q.size() == 0) || (bus.out_ready && q.size() == 1)));
            if (!bus.out_valid) begin
                check("idle_flags", 32'({bus.out_sol, bus.out_eol, bus.out_eof}), 32'd0);
            end else if (q.size() != 0) begin
                check("pixel", 32'({bus.binary, bus.out_sol, bus.out_eol, bus.out_eof}), 32'(q[0]));
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    pop_count++;
                    pop_log.push_back(bus.binary);
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    if (bus.out_eof) eof_pop_idx = pop_count;
                end
            end
            if (bus.in_valid && bus.in_ready) model_byte(bus.in_data);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && k < 200) begin
            k++;
            @(negedge clk);
        end
        if (k >= 200) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", 32'(q.size()), 32'd0);
        idle(2);
    endtask

    task automatic reset_dut();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [7:0] t1 [12] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF,
                            8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        int base;
        int k;
        logic [10:0] held;
        logic acc;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_binary", 32'(bus.binary), 32'd0);
        check("rst_flags", 32'({bus.out_sol, bus.out_eol, bus.out_eof}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: A5, F7 -> one 12-pixel line, padding nibble dropped
        bus.out_ready = 1'b1;
        pop_log.delete();
        send_byte(8'hA5);
        send_byte(8'hF7);
        drain();
        check("t1_count", 32'(pop_log.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < pop_log.size()) check("t1_pix", 32'(pop_log[i]), 32'(t1[i]));
        end

        // 2: four back-to-back bytes -> 24 pixels on consecutive cycles
        first_pop_cyc = -1;
        base = pop_count;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        drain();
        check("t2_count", 32'(pop_count - base), 32'd24);
        check("t2_span", 32'(last_pop_cyc - first_pop_cyc), 32'd23);

        // 3: stall mid-byte for three cycles
        send_byte(8'h3C);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        held = {bus.binary, bus.out_sol, bus.out_eol, bus.out_eof};
        for (int i = 0; i < 3; i++) begin
            check("t3_in_ready", 32'(bus.in_ready), 32'd0);
            check("t3_hold", 32'({bus.binary, bus.out_sol, bus.out_eol, bus.out_eof}), 32'(held));
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();

        // 4: full frame from a fresh reset, then wrap to row 0 col 0
        reset_dut();
        pop_log.delete();
        base = pop_count;
        eof_pop_idx = -1;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        drain();
        check("t4_eof_idx", 32'(eof_pop_idx - base), 32'd24);
        send_byte(8'h80);
        drain();
        check("t4_wrap_pix", 32'(pop_log[pop_log.size()-8]), 32'hFF);

        // 5: reset after three pixels of 0xFF
        base = pop_count;
        send_byte(8'hFF);
        bus.in_valid = 1'b0;
        k = 0;
        while (pop_count < base + 3 && k < 50) begin
            @(posedge clk);
            k++;
        end
        check("t5_wait", 32'(k < 50), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        send_byte(8'h00);
        drain();
        check("t5_count", 32'(pop_count - base), 32'd11);
        check("t5_last", 32'(pop_log[pop_log.size()-1]), 32'd0);

        // 6: sparse bytes
        for (int i = 0; i < 4; i++) begin
            send_byte(8'($urandom));
            idle(10);
        end
        drain();

        // random traffic with random backpressure
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc || !bus.in_valid) begin
                bus.in_valid = ($urandom_range(0, 2) != 0);
                bus.in_data  = 8'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
